usr_sequencer: RTL and testbench

//  Command sequencer for the 8-bit universal shift register (USR). Accepts one

---
 rtl/usr_pkg.sv | 22 ++
 rtl/usr_sequencer_shift_counter.sv | 44 ++++
 rtl/usr_sequencer.sv | 140 ++++++++++++++
 tb/tb_usr_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the USR command sequencer.
//  - USR ctrl encodings driven on usr_ctrl
//  - FSM state encoding for usr_sequencer
//  - clamp helper that limits a requested shift count to the data width
package usr_pkg;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_LOAD  = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;
    localparam logic [1:0] ST_DRAIN = 2'b11;

    // More than WIDTH shifts leaves only fill bits, so extra cycles are pointless.
    function automatic int unsigned clamp_count(input int unsigned cnt, input int unsigned lim);
        return (cnt > lim) ? lim : cnt;
    endfunction

endpackage

// File: rtl/usr_sequencer_shift_counter.sv
// Down-counter tracking the remaining shift cycles of a job.
// Ports:
//  clk       in   system clock
//  reset     in   asynchronous active-low reset
//  load      in   load load_val (has priority over dec)
//  dec       in   decrement by one
//  load_val  in   CNT_W value to load
//  is_one    out  registered flag, high while the count equals 1
module shift_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Next count value.
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = load_val;
        end else if (dec) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // Count register; is_one is registered from the next value so it lines up with cnt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            is_one <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            is_one <= (cnt_next == CNT_W'(1));
        end
    end

endmodule

// File: rtl/usr_sequencer.sv
// Command sequencer for an 8-bit universal shift register (USR).
// Accepts one job (data, direction, shift count) on start, drives the USR
// through load -> N shifts -> hold, then returns the USR contents with a
// one-cycle done pulse.
// Ports:
//  clk       in   system clock
//  reset     in   asynchronous active-low reset
//  start     in   job request, sampled only while idle
//  dir       in   0 = shift right, 1 = shift left
//  count     in   requested shift cycles (clamped to WIDTH)
//  data_in   in   value parallel-loaded into the USR
//  usr_q     in   USR output
//  usr_ctrl  out  USR ctrl: 00 hold, 01 right, 10 left, 11 load
//  usr_d     out  USR parallel data (latched job data)
//  busy      out  high whenever a job is in progress
//  done      out  one-cycle pulse, result valid in the same cycle
//  result    out  final USR value of the last job
module usr_sequencer
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_ctrl,
    output logic [WIDTH-1:0] usr_d,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             dir_q;
    logic [CNT_W-1:0] eff_q;
    logic [CNT_W-1:0] eff_in;

    logic             accept;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_is_one;
    logic [1:0]       ctrl_next;
    logic             done_next;
    logic [WIDTH-1:0] result_next;

    assign eff_in = CNT_W'(clamp_count(32'(count), WIDTH));

    shift_counter #(
        .CNT_W (CNT_W)
    ) u_shift_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (eff_q),
        .is_one   (cnt_is_one)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        done_next   = 1'b0;
        result_next = result;
        ctrl_next   = USR_HOLD;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (eff_q == '0) begin
                    state_next = ST_DRAIN;
                end else begin
                    cnt_load   = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_dec = 1'b1;
                if (cnt_is_one) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // USR has been holding for a cycle, so usr_q is settled.
                state_next  = ST_IDLE;
                done_next   = 1'b1;
                result_next = usr_q;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // ctrl follows the state being entered so it is valid for that whole state.
        case (state_next)
            ST_LOAD:  ctrl_next = USR_LOAD;
            ST_SHIFT: ctrl_next = dir_q ? USR_SHL : USR_SHR;
            default:  ctrl_next = USR_HOLD;
        endcase
    end

    // State, job registers and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            dir_q    <= 1'b0;
            eff_q    <= '0;
            usr_ctrl <= USR_HOLD;
            usr_d    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            state    <= state_next;
            usr_ctrl <= ctrl_next;
            busy     <= (state_next != ST_IDLE);
            done     <= done_next;
            result   <= result_next;
            if (accept) begin
                dir_q <= dir;
                eff_q <= eff_in;
                usr_d <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_usr_sequencer.sv
// Self-checking bench for usr_sequencer driving a behavioural 8-bit USR
// (zero fill). Table of jobs run back-to-back, plus hand-written reset,
// ignored-start and abort sequences.
module tb_usr_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       dir;
    logic [3:0] count;
    logic [7:0] data_in;
    logic [7:0] usr_q;
    logic [1:0] usr_ctrl;
    logic [7:0] usr_d;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int n_checks;
    int n_fail;
    logic [7:0] prev_result;

    typedef struct {
        logic [7:0] data;
        logic       dir;
        logic [3:0] count;
        logic [7:0] exp;
        int         lat;      // negedges after the LOAD cycle until done
        int         shifts;   // expected shift cycles
        int         pulse_at; // wait-loop index to pulse a stray start, -1 none
    } vec_t;

    vec_t vecs[8];

    usr_sequencer #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dir      (dir),
        .count    (count),
        .data_in  (data_in),
        .usr_q    (usr_q),
        .usr_ctrl (usr_ctrl),
        .usr_d    (usr_d),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Behavioural USR, zero fill on shifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            usr_q <= 8'h00;
        end else begin
            case (usr_ctrl)
                2'b01:   usr_q <= {1'b0, usr_q[7:1]};
                2'b10:   usr_q <= {usr_q[6:0], 1'b0};
                2'b11:   usr_q <= usr_d;
                default: usr_q <= usr_q;
            endcase
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Call at a negedge; returns at the negedge where done was seen.
    task automatic run_job(input vec_t v);
        int  lat;
        int  good;
        int  bad;
        bit  seen;
        logic [1:0] sh;
        sh      = v.dir ? 2'b10 : 2'b01;
        data_in = v.data;
        dir     = v.dir;
        count   = v.count;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_ctrl", int'(usr_ctrl), 3);
        check("load_busy", int'(busy), 1);
        check("load_done", int'(done), 0);
        check("result_held", int'(result), int'(prev_result));
        lat  = 0;
        good = 0;
        bad  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (i == v.pulse_at) begin
                start   = 1'b1;
                data_in = 8'h5A;
                count   = 4'd0;
                dir     = ~v.dir;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (usr_ctrl == sh) good++;
            else if (usr_ctrl != 2'b00) bad++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within 40 cycles for data %0h", v.data);
        end else begin
            check("latency", lat, v.lat);
            check("shift_cycles", good, v.shifts);
            check("stray_ctrl", bad, 0);
            check("result", int'(result), int'(v.exp));
            check("done_busy", int'(busy), 0);
        end
        prev_result = v.exp;
    endtask

    initial begin
        vec_t abort_v;
        n_checks    = 0;
        n_fail      = 0;
        prev_result = 8'h00;
        reset       = 1'b0;
        start       = 1'b1;
        dir         = 1'b0;
        count       = 4'd3;
        data_in     = 8'h99;

        //              data   dir  cnt    exp    lat shf pulse
        vecs[0] = '{8'hF6, 1'b0, 4'd1,  8'h7B, 3,  1, -1};
        vecs[1] = '{8'hF6, 1'b1, 4'd2,  8'hD8, 4,  2, -1};
        vecs[2] = '{8'hA5, 1'b0, 4'd0,  8'hA5, 2,  0, -1};
        vecs[3] = '{8'hC3, 1'b0, 4'd3,  8'h18, 5,  3, -1};
        vecs[4] = '{8'h81, 1'b1, 4'd8,  8'h00, 10, 8, -1};
        vecs[5] = '{8'h4B, 1'b1, 4'd4,  8'hB0, 6,  4, -1};
        vecs[6] = '{8'h3C, 1'b1, 4'd1,  8'h78, 3,  1, -1};
        vecs[7] = '{8'hFF, 1'b0, 4'd12, 8'h00, 10, 8, 3};

        // Reset held with start asserted.
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ctrl", int'(usr_ctrl), 0);
        check("rst_result", int'(result), 0);
        check("rst_usr_d", int'(usr_d), 0);
        reset = 1'b1;
        start = 1'b0;

        // Jobs back-to-back: each starts in the previous done cycle.
        for (int k = 0; k < 8; k++) begin
            run_job(vecs[k]);
        end

        // No second done from the stray start, and idle afterwards.
        begin
            int extra;
            extra = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check("no_extra_job", extra, 0);
        end

        // Abort a job during SHIFT with an asynchronous reset.
        data_in = 8'h99;
        dir     = 1'b0;
        count   = 4'd6;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_in_shift", int'(usr_ctrl), 1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_ctrl", int'(usr_ctrl), 0);
        check("abort_done", int'(done), 0);
        check("abort_result", int'(result), 0);
        begin
            int extra;
            extra = 0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            check("abort_quiet", extra, 0);
        end
        reset       = 1'b1;
        prev_result = 8'h00;
        abort_v     = '{8'h3C, 1'b1, 4'd1, 8'h78, 3, 1, -1};
        run_job(abort_v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
